mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage MIPS pipeline: the consumer of the EX/MEM pipeline register outputs produced by the execute stage. It holds a 256-word data memory, performs loads and stores, and resolves taken branches. It also registers the MEM/WB pipeline values that feed write-back, and keeps sticky misalignment and load/store statistics for debug.

## Interface
- DEPTH_LOG2, 8, data memory depth is 2^DEPTH_LOG2 32-bit words; word index = iALU[DEPTH_LOG2+1:2]
- CNT_W, 16, width of load/store statistic counters
- clkd  in  32  clock bus; only clkd[0] is used, all state updates on posedge clkd[0]
- rst_n  in  1  asynchronous active-low reset
- iMemtoReg, iMemRead, iMemWrite, iBranch, iRegWrite  in  1 each  EX/MEM control bits
- ipcplusimediate  in  32  branch target from EX
- izero  in  1  ALU zero flag from EX
- iALU  in  32  ALU result; byte address for loads/stores
- iBdat  in  32  store data
- iregW  in  5  destination register number
- oPCsrc  out  1  combinational: iBranch & izero
- oBranchTarget  out  32  combinational: ipcplusimediate
- oMemtoReg, oRegWrite  out  1 each  MEM/WB control
- oMemdat  out  32  MEM/WB load data
- oALU  out  32  MEM/WB ALU result
- oregW  out  5  MEM/WB destination register
- oMisalign  out  1  sticky misaligned-access flag
- oLoadCnt, oStoreCnt  out  CNT_W  saturating counts of completed loads/stores

## Operation
- Misaligned access (mis): (iMemRead | iMemWrite) & (iALU[1:0] != 0).
- Store: if iMemWrite & !mis, mem[idx] <= iBdat at the clock edge. Address bits above DEPTH_LOG2+1 are ignored, so addresses wrap modulo the memory size.
- Load: if iMemRead & !mis, oMemdat <= mem[idx] at the clock edge. Otherwise oMemdat <= 0.
- The read uses the array contents before the current edge. Only one of load/store exists per instruction. If both iMemRead and iMemWrite are asserted, the store wins and oMemdat <= 0.
- MEM/WB register, every edge:
  - oMemtoReg <= iMemtoReg
  - oALU <= iALU
  - oregW <= iregW
  - oRegWrite <= iRegWrite & !(iMemRead & mis); a misaligned load never writes the register file.
- oMisalign: set on any edge where mis = 1; cleared only by reset.
- oLoadCnt increments on each valid load. oStoreCnt increments on each valid store. Both saturate at 2^CNT_W-1 and do not wrap.
- Branch: oPCsrc and oBranchTarget are pure combinational functions of the current inputs, with no register. Flushing younger stages is the hazard logic's job, not this block's.
- Memory array contents are zero at time 0 and are not affected by rst_n.

## Timing
- Latency: inputs presented before edge N appear on the MEM/WB outputs after edge N (one cycle).
- A store at edge N followed by a load of the same address at edge N+1 returns the stored value. No bypass is needed.
- Reset (rst_n low, asynchronous): all MEM/WB outputs, oMisalign and both counters go to 0 immediately and hold while rst_n = 0. No store takes effect while rst_n = 0.
- Reset asserted mid-stream discards the in-flight instruction. The memory keeps all completed stores.
- Reset release: the first edge with rst_n = 1 performs normal operation.

## Test plan
- Store/load round trip: store 0xDEADBEEF to addr 0x10, then the next cycle load 0x10 with iMemtoReg = 1, iregW = 5 -> one cycle later oMemdat = 0xDEADBEEF, oregW = 5, oRegWrite = 1; oStoreCnt = 1, oLoadCnt = 1.
- Wrap-around: store 0x12345678 to addr 0x400, load addr 0x000 -> oMemdat = 0x12345678.
- Misaligned load at addr 0x13 with iRegWrite = 1 -> oRegWrite = 0, oMemdat = 0, oMisalign = 1 and stays 1 over 10 further aligned accesses; oLoadCnt unchanged. Misaligned store at 0x22 -> a later read of word 0x20 shows the old value.
- Branch: iBranch = 1, izero = 1, ipcplusimediate = 0x40 -> oPCsrc = 1, oBranchTarget = 0x40 in the same cycle; izero = 0 -> oPCsrc = 0.
- Non-memory ALU op: iALU = 0x55, iRegWrite = 1, iMemRead = iMemWrite = 0 -> oALU = 0x55, oMemdat = 0, counters unchanged.
- Reset mid-operation: pull rst_n low between clock edges while a load is in flight -> all outputs 0 without waiting for an edge. After release, a load of a previously stored address returns the stored data. With CNT_W = 2, 5 stores -> oStoreCnt = 3.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of a five-stage MIPS pipeline.
//
// Consumes the EX/MEM pipeline register outputs. Holds a word-addressed data memory,
// performs aligned loads and stores, exposes the branch decision combinationally, and
// registers the MEM/WB values consumed by write-back. Also keeps a sticky misaligned-
// access flag and saturating load/store counters for debug.
//
// Ports
//   clkd[31:0]           clock bus; only clkd[0] clocks this block
//   rst_n                asynchronous active-low reset
//   iMemtoReg/iRegWrite  write-back control forwarded to MEM/WB
//   iMemRead/iMemWrite   load / store request
//   iBranch, izero       branch decision inputs
//   ipcplusimediate      branch target from EX
//   iALU                 ALU result / byte address
//   iBdat                store data
//   iregW                destination register number
//   oPCsrc               iBranch & izero (combinational)
//   oBranchTarget        ipcplusimediate (combinational)
//   oMemtoReg, oRegWrite, oMemdat, oALU, oregW   MEM/WB register outputs
//   oMisalign            sticky misaligned-access flag
//   oLoadCnt, oStoreCnt  saturating counts of completed loads / stores

module mem_stage #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic [31:0]      clkd,
  input  logic             rst_n,
  input  logic             iMemtoReg,
  input  logic             iMemRead,
  input  logic             iMemWrite,
  input  logic             iBranch,
  input  logic             iRegWrite,
  input  logic [31:0]      ipcplusimediate,
  input  logic             izero,
  input  logic [31:0]      iALU,
  input  logic [31:0]      iBdat,
  input  logic [4:0]       iregW,
  output logic             oPCsrc,
  output logic [31:0]      oBranchTarget,
  output logic             oMemtoReg,
  output logic             oRegWrite,
  output logic [31:0]      oMemdat,
  output logic [31:0]      oALU,
  output logic [4:0]       oregW,
  output logic             oMisalign,
  output logic [CNT_W-1:0] oLoadCnt,
  output logic [CNT_W-1:0] oStoreCnt
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  // Data memory. Not reset: contents survive rst_n, so completed stores are kept.
  logic [31:0] r_mem [Depth];

  logic                  w_clk;
  logic                  w_mis;
  logic                  w_store;
  logic                  w_load;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_unused_clkd;

  logic             r_memtoreg;
  logic             r_regwrite;
  logic [31:0]      r_memdat;
  logic [31:0]      r_alu;
  logic [4:0]       r_regw;
  logic             r_misalign;
  logic [CNT_W-1:0] r_load_cnt;
  logic [CNT_W-1:0] r_store_cnt;

  assign w_clk         = clkd[0];
  assign w_unused_clkd = ^clkd[31:1];

  // Upper address bits are dropped so accesses wrap modulo the memory size.
  assign w_idx = iALU[DEPTH_LOG2+1:2];

  assign w_mis   = (iMemRead | iMemWrite) & (iALU[1:0] != 2'b00);
  // A store wins if both requests are raised; such a cycle is not counted as a load.
  assign w_store = iMemWrite & ~w_mis;
  assign w_load  = iMemRead & ~iMemWrite & ~w_mis;

  // Branch resolution is purely combinational; flushing is done elsewhere.
  assign oPCsrc        = iBranch & izero;
  assign oBranchTarget = ipcplusimediate;

  // Stores are suppressed while reset is held.
  always_ff @(posedge w_clk) begin
    if (rst_n && w_store) begin
      r_mem[w_idx] <= iBdat;
    end
  end

  // MEM/WB register, debug flag and counters.
  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_memtoreg  <= 1'b0;
      r_regwrite  <= 1'b0;
      r_memdat    <= 32'h0;
      r_alu       <= 32'h0;
      r_regw      <= 5'h0;
      r_misalign  <= 1'b0;
      r_load_cnt  <= '0;
      r_store_cnt <= '0;
    end else begin
      r_memtoreg <= iMemtoReg;
      r_alu      <= iALU;
      r_regw     <= iregW;
      // A misaligned load must never reach the register file.
      r_regwrite <= iRegWrite & ~(iMemRead & w_mis);
      // Read sees the array before this edge's store (no same-edge bypass).
      r_memdat   <= w_load ? r_mem[w_idx] : 32'h0;

      if (w_mis) begin
        r_misalign <= 1'b1;
      end
      if (w_load && (r_load_cnt != CntMax)) begin
        r_load_cnt <= r_load_cnt + CntOne;
      end
      if (w_store && (r_store_cnt != CntMax)) begin
        r_store_cnt <= r_store_cnt + CntOne;
      end
    end
  end

  assign oMemtoReg = r_memtoreg;
  assign oRegWrite = r_regwrite;
  assign oMemdat   = r_memdat;
  assign oALU      = r_alu;
  assign oregW     = r_regw;
  assign oMisalign = r_misalign;
  assign oLoadCnt  = r_load_cnt;
  assign oStoreCnt = r_store_cnt;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: two instances (default counter width and a 2-bit counter) share
// the same stimulus; a behavioural model predicts every registered and combinational
// output and is compared on each falling clock edge, plus literal spot checks.

module tb_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] clkd;
  assign clkd = {31'h2AAA5555, clk};

  logic        rst_n;
  logic        iMemtoReg, iMemRead, iMemWrite, iBranch, iRegWrite, izero;
  logic [31:0] ipcplusimediate, iALU, iBdat;
  logic [4:0]  iregW;

  logic        oPCsrc, oMemtoReg, oRegWrite, oMisalign;
  logic [31:0] oBranchTarget, oMemdat, oALU;
  logic [4:0]  oregW;
  logic [15:0] oLoadCnt, oStoreCnt;

  logic        s_oPCsrc, s_oMemtoReg, s_oRegWrite, s_oMisalign;
  logic [31:0] s_oBranchTarget, s_oMemdat, s_oALU;
  logic [4:0]  s_oregW;
  logic [1:0]  s_oLoadCnt, s_oStoreCnt;

  mem_stage u_dut (
    .clkd(clkd), .rst_n(rst_n),
    .iMemtoReg(iMemtoReg), .iMemRead(iMemRead), .iMemWrite(iMemWrite),
    .iBranch(iBranch), .iRegWrite(iRegWrite), .ipcplusimediate(ipcplusimediate),
    .izero(izero), .iALU(iALU), .iBdat(iBdat), .iregW(iregW),
    .oPCsrc(oPCsrc), .oBranchTarget(oBranchTarget), .oMemtoReg(oMemtoReg),
    .oRegWrite(oRegWrite), .oMemdat(oMemdat), .oALU(oALU), .oregW(oregW),
    .oMisalign(oMisalign), .oLoadCnt(oLoadCnt), .oStoreCnt(oStoreCnt)
  );

  mem_stage #(.DEPTH_LOG2(8), .CNT_W(2)) u_small (
    .clkd(clkd), .rst_n(rst_n),
    .iMemtoReg(iMemtoReg), .iMemRead(iMemRead), .iMemWrite(iMemWrite),
    .iBranch(iBranch), .iRegWrite(iRegWrite), .ipcplusimediate(ipcplusimediate),
    .izero(izero), .iALU(iALU), .iBdat(iBdat), .iregW(iregW),
    .oPCsrc(s_oPCsrc), .oBranchTarget(s_oBranchTarget), .oMemtoReg(s_oMemtoReg),
    .oRegWrite(s_oRegWrite), .oMemdat(s_oMemdat), .oALU(s_oALU), .oregW(s_oregW),
    .oMisalign(s_oMisalign), .oLoadCnt(s_oLoadCnt), .oStoreCnt(s_oStoreCnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [256];
  initial for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;

  logic        e_mtr, e_rw, e_mis;
  logic [31:0] e_memdat, e_alu;
  logic [4:0]  e_regw;
  int          e_ld, e_st;

  always @(posedge clk or negedge rst_n) begin : model
    bit is_mis;
    bit is_load;
    int idx;
    if (!rst_n) begin
      e_mtr = 0; e_rw = 0; e_mis = 0; e_memdat = 0; e_alu = 0; e_regw = 0;
      e_ld = 0; e_st = 0;
    end else begin
      is_mis  = (iMemRead || iMemWrite) && (iALU % 4 != 0);
      is_load = iMemRead && !iMemWrite && !is_mis;
      idx     = int'((iALU / 4) % 256);
      e_memdat = is_load ? m_mem[idx] : 32'h0;
      if (is_load) e_ld++;
      if (iMemWrite && !is_mis) begin
        m_mem[idx] = iBdat;
        e_st++;
      end
      if (is_mis) e_mis = 1;
      e_mtr  = iMemtoReg;
      e_alu  = iALU;
      e_regw = iregW;
      e_rw   = iRegWrite && !(iMemRead && is_mis);
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    chk("pcsrc",     32'(oPCsrc),    32'(iBranch && izero));
    chk("target",    oBranchTarget,  ipcplusimediate);
    chk("memtoreg",  32'(oMemtoReg), 32'(e_mtr));
    chk("regwrite",  32'(oRegWrite), 32'(e_rw));
    chk("memdat",    oMemdat,        e_memdat);
    chk("alu",       oALU,           e_alu);
    chk("regw",      32'(oregW),     32'(e_regw));
    chk("misalign",  32'(oMisalign), 32'(e_mis));
    chk("loadcnt",   32'(oLoadCnt),  32'(sat(e_ld, 65535)));
    chk("storecnt",  32'(oStoreCnt), 32'(sat(e_st, 65535)));
    chk("s_memdat",  s_oMemdat,      e_memdat);
    chk("s_loadcnt", 32'(s_oLoadCnt),  32'(sat(e_ld, 3)));
    chk("s_storecnt",32'(s_oStoreCnt), 32'(sat(e_st, 3)));
  end

  // ---------------- directed stimulus ----------------
  // Applies one instruction and returns once its MEM/WB result is visible.
  task automatic op(input logic rd, input logic wr, input logic mtr, input logic rw,
                    input logic [31:0] alu, input logic [31:0] bdat, input logic [4:0] rg);
    iMemRead = rd; iMemWrite = wr; iMemtoReg = mtr; iRegWrite = rw;
    iALU = alu; iBdat = bdat; iregW = rg;
    @(negedge clk); #2;
  endtask

  initial begin
    rst_n = 1'b1;
    iMemtoReg = 0; iMemRead = 0; iMemWrite = 0; iBranch = 0; iRegWrite = 0; izero = 0;
    ipcplusimediate = 0; iALU = 0; iBdat = 0; iregW = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_memdat", oMemdat, 32'h0);
    chk("rst_storecnt", 32'(oStoreCnt), 32'h0);
    chk("rst_misalign", 32'(oMisalign), 32'h0);
    rst_n = 1'b1;

    // Store / load round trip
    op(0, 1, 0, 0, 32'h10, 32'hDEADBEEF, 5'd0);
    op(1, 0, 1, 1, 32'h10, 32'h0, 5'd5);
    chk("rt_memdat", oMemdat, 32'hDEADBEEF);
    chk("rt_regw", 32'(oregW), 32'd5);
    chk("rt_regwrite", 32'(oRegWrite), 32'd1);
    chk("rt_storecnt", 32'(oStoreCnt), 32'd1);
    chk("rt_loadcnt", 32'(oLoadCnt), 32'd1);

    // Address wrap-around
    op(0, 1, 0, 0, 32'h400, 32'h12345678, 5'd0);
    op(1, 0, 1, 1, 32'h000, 32'h0, 5'd3);
    chk("wrap_memdat", oMemdat, 32'h12345678);

    // Misaligned load, sticky flag
    op(1, 0, 1, 1, 32'h13, 32'h0, 5'd7);
    chk("mis_regwrite", 32'(oRegWrite), 32'd0);
    chk("mis_memdat", oMemdat, 32'h0);
    chk("mis_flag", 32'(oMisalign), 32'd1);
    chk("mis_loadcnt", 32'(oLoadCnt), 32'd2);
    for (int i = 0; i < 10; i++) begin
      op(1, 0, 1, 1, 32'h10, 32'h0, 5'd1);
      chk("mis_sticky", 32'(oMisalign), 32'd1);
    end

    // Misaligned store leaves the word untouched
    op(0, 1, 0, 0, 32'h20, 32'hAAAA5555, 5'd0);
    op(0, 1, 0, 0, 32'h22, 32'hFFFFFFFF, 5'd0);
    chk("mis_st_cnt", 32'(oStoreCnt), 32'd3);
    op(1, 0, 1, 1, 32'h20, 32'h0, 5'd2);
    chk("mis_st_old", oMemdat, 32'hAAAA5555);

    // Branch resolution is combinational
    iBranch = 1; izero = 1; ipcplusimediate = 32'h40;
    #1;
    chk("br_taken", 32'(oPCsrc), 32'd1);
    chk("br_target", oBranchTarget, 32'h40);
    izero = 0;
    #1;
    chk("br_not_taken", 32'(oPCsrc), 32'd0);

    // Non-memory ALU op
    op(0, 0, 0, 1, 32'h55, 32'h0, 5'd9);
    chk("alu_val", oALU, 32'h55);
    chk("alu_memdat", oMemdat, 32'h0);
    chk("alu_loadcnt", 32'(oLoadCnt), 32'd13);
    chk("alu_storecnt", 32'(oStoreCnt), 32'd3);
    iBranch = 0;

    // Read and write together: store wins
    op(1, 1, 0, 0, 32'h30, 32'h7, 5'd0);
    chk("both_memdat", oMemdat, 32'h0);
    chk("both_storecnt", 32'(oStoreCnt), 32'd4);
    chk("both_sat", 32'(s_oStoreCnt), 32'd3);
    op(1, 0, 1, 1, 32'h30, 32'h0, 5'd2);
    chk("both_readback", oMemdat, 32'h7);

    // Reset mid-operation with a load in flight
    iMemRead = 1; iMemWrite = 0; iMemtoReg = 1; iRegWrite = 1; iALU = 32'h10; iregW = 5'd4;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_memdat", oMemdat, 32'h0);
    chk("arst_alu", oALU, 32'h0);
    chk("arst_regw", 32'(oregW), 32'h0);
    chk("arst_regwrite", 32'(oRegWrite), 32'h0);
    chk("arst_misalign", 32'(oMisalign), 32'h0);
    chk("arst_loadcnt", 32'(oLoadCnt), 32'h0);
    chk("arst_storecnt", 32'(oStoreCnt), 32'h0);
    // A store held during reset must be ignored
    iMemRead = 0; iMemWrite = 1; iBdat = 32'h999;
    @(negedge clk); #2;
    chk("arst_hold_cnt", 32'(oStoreCnt), 32'h0);
    iMemRead = 1; iMemWrite = 0; iALU = 32'h10; iregW = 5'd6;
    rst_n = 1'b1;
    @(negedge clk); #2;
    chk("post_rst_memdat", oMemdat, 32'hDEADBEEF);
    chk("post_rst_loadcnt", 32'(oLoadCnt), 32'd1);

    // Saturation of the 2-bit counter
    for (int i = 0; i < 5; i++) op(0, 1, 0, 0, 32'h100 + 32'(4 * i), 32'(i + 1), 5'd0);
    chk("sat_big", 32'(oStoreCnt), 32'd5);
    chk("sat_small", 32'(s_oStoreCnt), 32'd3);
    op(1, 0, 1, 1, 32'h108, 32'h0, 5'd8);
    chk("sat_readback", oMemdat, 32'd3);

    op(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
